// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin arbiter giving a fetch port and a load/store port
// access to one shared memory bus, with address legality checking.
module memory_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MEMORY_DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  f_req,
  input  logic [DATA_WIDTH-1:0] f_addr,
  output logic [DATA_WIDTH-1:0] f_rdata,
  output logic                  f_ack,
  output logic                  f_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ack,
  output logic                  d_err,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);
  localparam logic [DATA_WIDTH-1:0] ROM_BASE = DATA_WIDTH'(32'h0040_0000);
  localparam logic [DATA_WIDTH-1:0] ROM_END = ROM_BASE + DATA_WIDTH'(4 * MEMORY_DEPTH);
  localparam logic [DATA_WIDTH-1:0] RAM_BASE = DATA_WIDTH'(32'h1001_0000);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state;
  logic gnt, last, ok_q;
  logic sel, we, in_rom, in_ram, ok;
  logic [DATA_WIDTH-1:0] addr;
  assign sel = (f_req && d_req) ? ~last : d_req;
  assign addr = sel ? d_addr : f_addr;
  assign we = sel & d_we;
  assign in_rom = addr >= ROM_BASE && addr < ROM_END;
  assign in_ram = addr >= RAM_BASE;
  // fetches must hit ROM, stores must hit RAM, loads may hit either
  assign ok = addr[1:0] == 2'b00 && (sel ? (we ? in_ram : (in_rom || in_ram)) : in_rom);
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt <= 1'b0;
      last <= 1'b1;
      ok_q <= 1'b0;
      f_rdata <= '0;
      d_rdata <= '0;
      f_ack <= 1'b0;
      d_ack <= 1'b0;
      f_err <= 1'b0;
      d_err <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (f_req || d_req) begin
          state <= ACCESS;
          gnt <= sel;
          last <= sel;
          ok_q <= ok;
          mem_we <= we && ok;
          mem_addr <= ok ? addr : '0;
          mem_wdata <= (ok && we) ? d_wdata : '0;
        end
        ACCESS: begin
          state <= RESP;
          mem_we <= 1'b0;
          mem_addr <= '0;
          mem_wdata <= '0;
          if (ok_q && !mem_we && !gnt) f_rdata <= mem_rdata;
          if (ok_q && !mem_we && gnt) d_rdata <= mem_rdata;
          f_ack <= ~gnt;
          d_ack <= gnt;
          f_err <= ~gnt & ~ok_q;
          d_err <= gnt & ~ok_q;
        end
        default: begin
          state <= IDLE;
          f_ack <= 1'b0;
          d_ack <= 1'b0;
          f_err <= 1'b0;
          d_err <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: transaction-level model drives a scoreboard queue that a
// per-cycle monitor checks against the arbiter outputs.
module tb_memory_arbiter;
  logic clk = 0, rst_n = 0;
  logic f_req = 0, d_req = 0, d_we = 0;
  logic [31:0] f_addr = 0, d_addr = 0, d_wdata = 0;
  logic [31:0] f_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic f_ack, f_err, d_ack, d_err, mem_we, busy;
  int cyc = 0, vectors = 0, miscompares = 0;
  logic mon_off = 0, last_m = 1;
  logic [31:0] m_fr = 0, m_dr = 0;
  typedef struct {
    int cyc;
    logic port, err, mwe;
    logic [31:0] fr, dr, ma, mwd;
  } exp_t;
  exp_t q[$];

  memory_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_ack(f_ack), .f_err(f_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_ack(d_ack), .d_err(d_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_of(input logic [31:0] a);
    return a == 32'h0040_0004 ? 32'h0050_0093 : a * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction
  always_comb mem_rdata = mem_of(mem_addr);

  function automatic logic legal(input logic port, input logic wr, input logic [31:0] a);
    logic rom, ram;
    rom = a >= 32'h0040_0000 && a < 32'h0040_0000 + 4 * 64;
    ram = a >= 32'h1001_0000;
    if (a[1:0] != 2'b00) return 1'b0;
    if (!port) return rom;
    return wr ? ram : (rom || ram);
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 4))
      0: return 32'h0040_0000 + ($urandom_range(0, 63) << 2);
      1: return 32'h1001_0000 + ($urandom_range(0, 1023) << 2);
      2: return 32'h1001_0001 + $urandom_range(0, 400);
      3: return 32'h0040_0100 + ($urandom_range(0, 15) << 2);
      default: return 32'($urandom_range(0, 32'h003F_FFFF)) & 32'hFFFF_FFFC;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_f_ack"}, f_ack, 0);
    chk({tag, "_d_ack"}, d_ack, 0);
    chk({tag, "_f_err"}, f_err, 0);
    chk({tag, "_d_err"}, d_err, 0);
    chk({tag, "_f_rdata"}, f_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Called in an idle cycle; predicts the grant and steps to the next idle cycle.
  task automatic slot(input int mode);
    exp_t e;
    logic w;
    logic [31:0] a;
    if (!f_req && !d_req) begin
      @(posedge clk); #1;
      return;
    end
    w = (f_req && d_req) ? !last_m : d_req;
    last_m = w;
    a = w ? d_addr : f_addr;
    e.port = w;
    e.cyc = cyc + 2;
    e.err = !legal(w, w && d_we, a);
    e.mwe = !e.err && w && d_we;
    e.ma = e.err ? 32'h0 : a;
    e.mwd = d_wdata;
    if (!e.err && !(w && d_we)) begin
      if (w) m_dr = mem_of(a);
      else m_fr = mem_of(a);
    end
    e.fr = m_fr;
    e.dr = m_dr;
    q.push_back(e);
    @(posedge clk); #1;
    if (mode == 0) begin if (w) d_req = 0; else f_req = 0; end
    @(posedge clk); #1;
    if (mode == 1) begin if (w) d_req = 0; else f_req = 0; end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    logic acc, ack;
    exp_t e;
    if (rst_n && !mon_off) begin
      acc = q.size() > 0 && cyc == q[0].cyc - 1;
      ack = q.size() > 0 && cyc == q[0].cyc;
      if (q.size() > 0) e = q[0];
      chk("busy", busy, acc || ack);
      chk("ack_overlap", f_ack & d_ack, 0);
      chk("mem_we", mem_we, acc && e.mwe);
      chk("mem_addr", mem_addr, acc ? e.ma : 32'h0);
      if (acc && e.mwe) chk("mem_wdata", mem_wdata, e.mwd);
      else if (!acc) chk("mem_wdata_idle", mem_wdata, 0);
      chk("f_ack", f_ack, ack && !e.port);
      chk("d_ack", d_ack, ack && e.port);
      chk("f_err", f_err, ack && !e.port && e.err);
      chk("d_err", d_err, ack && e.port && e.err);
      if (ack) begin
        chk("f_rdata", f_rdata, e.fr);
        chk("d_rdata", d_rdata, e.dr);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    rst_n = 1;
    f_req = 1; f_addr = 32'h0040_0008;
    d_req = 1; d_addr = 32'h1001_0004;
    repeat (4) slot(2);
    f_req = 0; d_req = 0;
    f_req = 1; f_addr = 32'h0040_0004;
    slot(0);
    d_req = 1; d_we = 1; d_addr = 32'h1001_0008; d_wdata = 32'hDEAD_BEEF;
    slot(0);
    d_we = 0;
    d_req = 1; d_addr = 32'h1001_0002;
    slot(1);
    f_req = 1; f_addr = 32'h1001_0000;
    slot(0);
    d_req = 1; d_we = 1; d_addr = 32'h0040_0000; d_wdata = 32'h1234_5678;
    slot(0);
    d_we = 0;
    f_req = 1; f_addr = 32'h0040_000C;
    slot(0);
    f_req = 1; f_addr = 32'h0040_0010;
    d_req = 1; d_addr = 32'h1001_0000;
    slot(0);
    slot(0);
    mon_off = 1;
    d_req = 1; d_we = 1; d_addr = 32'h1001_0010; d_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    chk("rst_access_we", mem_we, 1);
    rst_n = 0; d_req = 0; d_we = 0;
    @(posedge clk); #1;
    check_zero("rst_in_access");
    rst_n = 1;
    last_m = 1; m_fr = 0; m_dr = 0;
    @(posedge clk); #1;
    chk("rst_no_ack", f_ack | d_ack, 0);
    mon_off = 0;
    f_req = 1; f_addr = 32'h0040_0020;
    d_req = 1; d_addr = 32'h0040_0024;
    slot(0);
    slot(0);
    for (int i = 0; i < 300; i++) begin
      if (!f_req && $urandom_range(0, 1) == 1) begin
        f_req = 1; f_addr = rand_addr();
      end
      if (!d_req && $urandom_range(0, 1) == 1) begin
        d_req = 1; d_we = 1'($urandom_range(0, 1)); d_addr = rand_addr(); d_wdata = $urandom;
      end
      slot(int'($urandom_range(0, 2)));
    end
    f_req = 0; d_req = 0;
    repeat (4) @(posedge clk);
    #1 chk("drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
